// File: rtl/cluster_pkg.sv
// rtl/cluster_pkg.sv - shared sizes, address type and state enum for the cluster priority encoder
package cluster_pkg;

  localparam int MXSBITS    = 1536;
  localparam int MXSEGS     = 24;
  localparam int SEGSIZE    = MXSBITS / MXSEGS;
  localparam int MXCLUSTERS = 8;
  localparam int ADRB       = 11;
  localparam int SEGB       = 5;
  localparam int OFFB       = 6;

  typedef logic [ADRB-1:0] cluster_adr_t;

  localparam cluster_adr_t INVALID_ADR = 11'h7FF;

  typedef enum logic {IDLE, COLLECT} state_t;

  // SEGSIZE is 64, so segment*64 + offset is a plain concatenation
  function automatic cluster_adr_t seg_adr(input logic [SEGB-1:0] idx, input logic [OFFB-1:0] off);
    return {idx, off};
  endfunction

endpackage

// File: rtl/cluster_segment_encoder.sv
// rtl/cluster_segment_encoder.sv - registered any/lowest-set-bit offset for one 64-bit segment
module cluster_segment_encoder
  import cluster_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic [SEGSIZE-1:0] seg_bits,
  output logic               any,
  output logic [OFFB-1:0]    off
);

  logic [OFFB-1:0] off_c;

  always_comb begin
    off_c = '0;
    for (int i = SEGSIZE - 1; i >= 0; i--) begin
      if (seg_bits[i]) off_c = OFFB'(i);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      any <= 1'b0;
      off <= '0;
    end else begin
      any <= |seg_bits;
      off <= off_c;
    end
  end

endmodule

// File: rtl/cluster_priority_encoder.sv
// rtl/cluster_priority_encoder.sv - 3-stage LSB priority encoder with per-frame cluster list
// Optional address-order checker: CLUSTER_ORDER_CHECK_EN
module cluster_priority_encoder
  import cluster_pkg::*;
(
  input  logic                       clock,
  input  logic                       global_reset_n,
  input  logic                       frame_start,
  input  logic [MXSBITS-1:0]         vpfs_in,
  output logic [ADRB-1:0]            adr_out,
  output logic                       adr_valid,
  output logic [MXCLUSTERS*ADRB-1:0] clusters_out,
  output logic [3:0]                 cluster_cnt,
  output logic                       overflow,
  output logic                       clusters_valid,
  output logic                       order_err
);

  logic                seg_any [MXSEGS];
  logic [OFFB-1:0]     seg_off [MXSEGS];
  logic [SEGB-1:0]     sel_idx;
  logic [OFFB-1:0]     sel_off;
  logic                sel_any;
  logic [SEGB-1:0]     s2_idx;
  logic [OFFB-1:0]     s2_off;
  logic                s2_any;
  logic [2:0]          fs_pipe;
  logic                fs3;
  state_t              state, state_next;
  logic                emit;
  cluster_adr_t        acc [MXCLUSTERS];
  logic [3:0]          cnt;
  logic                ovf_acc;

  for (genvar s = 0; s < MXSEGS; s++) begin : g_seg
    cluster_segment_encoder u_seg (
      .clock    (clock),
      .reset_n  (global_reset_n),
      .seg_bits (vpfs_in[s*SEGSIZE +: SEGSIZE]),
      .any      (seg_any[s]),
      .off      (seg_off[s])
    );
  end

  always_comb begin
    sel_idx = '0;
    sel_off = '0;
    sel_any = 1'b0;
    for (int s = MXSEGS - 1; s >= 0; s--) begin
      if (seg_any[s]) begin
        sel_idx = SEGB'(s);
        sel_off = seg_off[s];
        sel_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      s2_idx    <= '0;
      s2_off    <= '0;
      s2_any    <= 1'b0;
      adr_out   <= INVALID_ADR;
      adr_valid <= 1'b0;
      fs_pipe   <= '0;
    end else begin
      s2_idx    <= sel_idx;
      s2_off    <= sel_off;
      s2_any    <= sel_any;
      adr_out   <= s2_any ? seg_adr(s2_idx, s2_off) : INVALID_ADR;
      adr_valid <= s2_any;
      fs_pipe   <= {fs_pipe[1:0], frame_start};
    end
  end

  assign fs3 = fs_pipe[2];

  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) state <= IDLE;
    else                 state <= state_next;
  end

  always_comb begin
    state_next = state;
    emit       = 1'b0;
    case (state)
      IDLE:    if (fs3) state_next = COLLECT;
      COLLECT: emit = fs3;
      default: state_next = IDLE;
    endcase
  end

  // A cluster arriving with fs3 opens the new frame rather than closing the old one
  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      for (int i = 0; i < MXCLUSTERS; i++) acc[i] <= INVALID_ADR;
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else if (fs3) begin
      for (int i = 0; i < MXCLUSTERS; i++) acc[i] <= INVALID_ADR;
      if (adr_valid) acc[0] <= adr_out;
      cnt     <= adr_valid ? 4'd1 : 4'd0;
      ovf_acc <= 1'b0;
    end else if (state == COLLECT && adr_valid) begin
      if (cnt == 4'(MXCLUSTERS)) begin
        ovf_acc <= 1'b1;
      end else begin
        acc[cnt[2:0]] <= adr_out;
        cnt           <= cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      clusters_out   <= {MXCLUSTERS{INVALID_ADR}};
      cluster_cnt    <= '0;
      overflow       <= 1'b0;
      clusters_valid <= 1'b0;
    end else begin
      clusters_valid <= emit;
      if (emit) begin
        for (int i = 0; i < MXCLUSTERS; i++) clusters_out[i*ADRB +: ADRB] <= acc[i];
        cluster_cnt <= cnt;
        overflow    <= ovf_acc;
      end
    end
  end

`ifdef CLUSTER_ORDER_CHECK_EN
  cluster_adr_t prev_adr;
  logic         have_prev;

  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      prev_adr  <= INVALID_ADR;
      have_prev <= 1'b0;
      order_err <= 1'b0;
    end else if (fs3) begin
      prev_adr  <= adr_out;
      have_prev <= adr_valid;
    end else if (state == COLLECT && adr_valid) begin
      if (have_prev && adr_out <= prev_adr) order_err <= 1'b1;
      prev_adr  <= adr_out;
      have_prev <= 1'b1;
    end
  end
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_cluster_priority_encoder.sv
// tb/tb_cluster_priority_encoder.sv - directed self-checking bench for cluster_priority_encoder
module tb_cluster_priority_encoder;

  logic          clock = 1'b0;
  logic          global_reset_n;
  logic          frame_start;
  logic [1535:0] vpfs_in;
  logic [10:0]   adr_out;
  logic          adr_valid;
  logic [87:0]   clusters_out;
  logic [3:0]    cluster_cnt;
  logic          overflow;
  logic          clusters_valid;
  logic          order_err;

  int            errors = 0;
  int            checks = 0;
  logic [87:0]   exp_list;
  logic [1535:0] v;
  int            bl [10] = '{3, 10, 100, 200, 300, 400, 500, 600, 700, 800};

`ifdef CLUSTER_ORDER_CHECK_EN
  localparam bit ORDER_EN = 1'b1;
`else
  localparam bit ORDER_EN = 1'b0;
`endif

  localparam logic [87:0] ALL_INV = {8{11'h7FF}};

  cluster_priority_encoder dut (
    .clock          (clock),
    .global_reset_n (global_reset_n),
    .frame_start    (frame_start),
    .vpfs_in        (vpfs_in),
    .adr_out        (adr_out),
    .adr_valid      (adr_valid),
    .clusters_out   (clusters_out),
    .cluster_cnt    (cluster_cnt),
    .overflow       (overflow),
    .clusters_valid (clusters_valid),
    .order_err      (order_err)
  );

  always #5 clock = ~clock;

  function automatic logic [1535:0] bitv(input int i);
    logic [1535:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic fs, input logic [1535:0] vec);
    frame_start = fs;
    vpfs_in     = vec;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_adr"}, adr_out, 11'h7FF);
    chk({tag, "_adr_valid"}, adr_valid, 1'b0);
    chk({tag, "_list"}, clusters_out, ALL_INV);
    chk({tag, "_cnt"}, cluster_cnt, 4'd0);
    chk({tag, "_ovf"}, overflow, 1'b0);
    chk({tag, "_cv"}, clusters_valid, 1'b0);
    chk({tag, "_order"}, order_err, 1'b0);
  endtask

  initial begin
    global_reset_n = 1'b0;
    frame_start    = 1'b0;
    vpfs_in        = '0;
    repeat (3) @(posedge clock);
    #1;
    chk_reset_state("reset");
    global_reset_n = 1'b1;

    // single cluster at 5, first frame after reset produces no list
    drive(1'b1, bitv(5));
    drive(1'b0, '0);
    drive(1'b0, '0);
    chk("adr5", adr_out, 11'd5);
    chk("adr5_valid", adr_valid, 1'b1);
    drive(1'b0, '0);
    chk("idle_no_list", clusters_valid, 1'b0);
    chk("adr_idle_inv", adr_out, 11'h7FF);
    drive(1'b1, '0);
    drive(1'b0, '0);
    drive(1'b0, '0);
    drive(1'b0, '0);
    exp_list = ALL_INV;
    exp_list[0 +: 11] = 11'd5;
    chk("f1_cv", clusters_valid, 1'b1);
    chk("f1_cnt", cluster_cnt, 4'd1);
    chk("f1_list", clusters_out, exp_list);
    chk("f1_ovf", overflow, 1'b0);
    drive(1'b0, '0);
    chk("f1_pulse_end", clusters_valid, 1'b0);
    chk("f1_cnt_hold", cluster_cnt, 4'd1);

    // truncator-style frame {0,63,64,1535}; closes the all-zero frame
    v = bitv(0) | bitv(63) | bitv(64) | bitv(1535);
    drive(1'b1, v);
    v[0] = 1'b0;
    drive(1'b0, v);
    v[63] = 1'b0;
    drive(1'b0, v);
    chk("seq_adr0", adr_out, 11'd0);
    chk("seq_valid0", adr_valid, 1'b1);
    v[64] = 1'b0;
    drive(1'b0, v);
    chk("seq_adr63", adr_out, 11'd63);
    chk("zero_cv", clusters_valid, 1'b1);
    chk("zero_cnt", cluster_cnt, 4'd0);
    chk("zero_list", clusters_out, ALL_INV);
    drive(1'b0, '0);
    chk("seq_adr64", adr_out, 11'd64);
    drive(1'b0, '0);
    chk("seq_adr1535", adr_out, 11'd1535);
    drive(1'b0, '0);

    // ten clusters; closes the four-cluster frame
    v = '0;
    for (int k = 0; k < 10; k++) v[bl[k]] = 1'b1;
    drive(1'b1, v);
    for (int k = 0; k < 9; k++) begin
      v[bl[k]] = 1'b0;
      drive(1'b0, v);
      if (k == 2) begin
        exp_list = ALL_INV;
        exp_list[0*11 +: 11] = 11'd0;
        exp_list[1*11 +: 11] = 11'd63;
        exp_list[2*11 +: 11] = 11'd64;
        exp_list[3*11 +: 11] = 11'd1535;
        chk("f4_cv", clusters_valid, 1'b1);
        chk("f4_cnt", cluster_cnt, 4'd4);
        chk("f4_list", clusters_out, exp_list);
      end
    end
    drive(1'b0, '0);
    drive(1'b0, '0);
    drive(1'b0, '0);

    // frame starting with a coincident cluster at 40 closes the overflow frame
    drive(1'b1, bitv(40));
    drive(1'b0, '0);
    drive(1'b0, '0);
    drive(1'b0, '0);
    for (int k = 0; k < 8; k++) exp_list[k*11 +: 11] = 11'(bl[k]);
    chk("ovf_cv", clusters_valid, 1'b1);
    chk("ovf_cnt", cluster_cnt, 4'd8);
    chk("ovf_list", clusters_out, exp_list);
    chk("ovf_flag", overflow, 1'b1);

    // 700 coincides with frame_start: belongs to the new frame
    drive(1'b1, bitv(700));
    drive(1'b0, '0);
    drive(1'b0, '0);
    chk("adr700", adr_out, 11'd700);
    chk("adr700_valid", adr_valid, 1'b1);
    drive(1'b0, '0);
    exp_list = ALL_INV;
    exp_list[0 +: 11] = 11'd40;
    chk("f40_cnt", cluster_cnt, 4'd1);
    chk("f40_list", clusters_out, exp_list);
    chk("f40_ovf", overflow, 1'b0);
    drive(1'b1, '0);
    drive(1'b0, '0);
    drive(1'b0, '0);
    drive(1'b0, '0);
    exp_list[0 +: 11] = 11'd700;
    chk("f700_cv", clusters_valid, 1'b1);
    chk("f700_cnt", cluster_cnt, 4'd1);
    chk("f700_list", clusters_out, exp_list);

    // reset mid-frame
    drive(1'b1, bitv(9));
    drive(1'b0, '0);
    global_reset_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    @(posedge clock);
    #1;
    global_reset_n = 1'b1;
    drive(1'b1, bitv(20));
    drive(1'b0, '0);
    drive(1'b0, '0);
    chk("adr20", adr_out, 11'd20);
    drive(1'b0, '0);
    chk("rst_first_fs_no_list", clusters_valid, 1'b0);
    drive(1'b1, '0);
    drive(1'b0, '0);
    drive(1'b0, '0);
    drive(1'b0, '0);
    exp_list = ALL_INV;
    exp_list[0 +: 11] = 11'd20;
    chk("rst_second_cv", clusters_valid, 1'b1);
    chk("rst_second_cnt", cluster_cnt, 4'd1);
    chk("rst_second_list", clusters_out, exp_list);

    // out-of-order 100 then 50
    chk("order_pre", order_err, 1'b0);
    drive(1'b1, bitv(100));
    drive(1'b0, bitv(50));
    drive(1'b0, '0);
    drive(1'b0, '0);
    chk("order_adr50", adr_out, 11'd50);
    drive(1'b0, '0);
    chk("order_set", order_err, ORDER_EN);
    drive(1'b1, '0);
    drive(1'b0, '0);
    drive(1'b0, '0);
    drive(1'b0, '0);
    chk("order_sticky", order_err, ORDER_EN);
    global_reset_n = 1'b0;
    #1;
    chk("order_rst_clear", order_err, 1'b0);
    @(posedge clock);
    #1;
    global_reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
